// File: rtl/alu_op_sequencer.sv
// Request/response sequencer that drives an external 32-bit ALU, running single-cycle
// logic/arithmetic ops directly and unsigned multiply as a 32-step shift-add through the ALU.
module alu_op_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_overflow,
    output logic              rsp_err,
    output logic              alu_ainvert,
    output logic              alu_binvert,
    output logic              alu_carryin,
    output logic [1:0]        alu_operation,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_overflow
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_MULU = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic       ainvert;
        logic       binvert;
        logic       carryin;
        logic [1:0] operation;
    } alu_ctrl_t;

    localparam alu_ctrl_t CTRL_NONE = 5'b000_00;
    localparam alu_ctrl_t CTRL_ADD  = 5'b000_10;

    function automatic alu_ctrl_t decode_ctrl(input logic [2:0] op);
        alu_ctrl_t c;
        case (op)
            OP_AND:  c = 5'b000_00;
            OP_OR:   c = 5'b000_01;
            OP_ADD:  c = 5'b000_10;
            OP_SUB:  c = 5'b011_10;
            OP_SLT:  c = 5'b011_11;
            OP_NOR:  c = 5'b110_00;
            default: c = CTRL_NONE;
        endcase
        return c;
    endfunction

    // Only the adder-based ops have a meaningful overflow flag.
    function automatic logic reports_overflow(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

    state_t            state;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [CNT_W-1:0]  cnt;
    alu_ctrl_t         ctrl_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;

    logic [CNT_W-1:0]  cnt_nxt;
    logic [DATA_W-1:0] mcand_nxt;

    assign cnt_nxt   = cnt + CNT_W'(1);
    assign mcand_nxt = a_q << 1;

    assign req_ready     = reset_n && (state == IDLE);
    assign alu_ainvert   = ctrl_q.ainvert;
    assign alu_binvert   = ctrl_q.binvert;
    assign alu_carryin   = ctrl_q.carryin;
    assign alu_operation = ctrl_q.operation;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;

    // During MUL the alu_a register is the running accumulator; a_q holds the
    // shifting multiplicand and b_q the multiplier.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cnt          <= '0;
            ctrl_q       <= CTRL_NONE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q <= req_op;
                        a_q  <= req_a;
                        b_q  <= req_b;
                        cnt  <= '0;
                        if (req_op == OP_ILL) begin
                            state        <= RESP;
                            rsp_valid    <= 1'b1;
                            rsp_result   <= '0;
                            rsp_zero     <= 1'b1;
                            rsp_overflow <= 1'b0;
                            rsp_err      <= 1'b1;
                        end else if (req_op == OP_MULU) begin
                            state   <= MUL;
                            ctrl_q  <= CTRL_ADD;
                            alu_a_q <= '0;
                            alu_b_q <= req_b[0] ? req_a : '0;
                        end else begin
                            state   <= EXEC;
                            ctrl_q  <= decode_ctrl(req_op);
                            alu_a_q <= req_a;
                            alu_b_q <= req_b;
                        end
                    end
                end
                EXEC: begin
                    state        <= RESP;
                    rsp_valid    <= 1'b1;
                    rsp_result   <= alu_result;
                    rsp_zero     <= alu_zero;
                    rsp_overflow <= reports_overflow(op_q) ? alu_overflow : 1'b0;
                    rsp_err      <= 1'b0;
                    ctrl_q       <= CTRL_NONE;
                    alu_a_q      <= '0;
                    alu_b_q      <= '0;
                end
                MUL: begin
                    a_q <= mcand_nxt;
                    cnt <= cnt_nxt;
                    if (cnt == CNT_LAST) begin
                        state        <= RESP;
                        rsp_valid    <= 1'b1;
                        rsp_result   <= alu_result;
                        rsp_zero     <= (alu_result == '0);
                        rsp_overflow <= 1'b0;
                        rsp_err      <= 1'b0;
                        ctrl_q       <= CTRL_NONE;
                        alu_a_q      <= '0;
                        alu_b_q      <= '0;
                    end else begin
                        alu_a_q <= alu_result;
                        alu_b_q <= b_q[cnt_nxt] ? mcand_nxt : '0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: models the external ALU, compares every response against an
// arithmetic reference and checks latency, backpressure and reset behaviour.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_overflow, rsp_err;
    logic        alu_ainvert, alu_binvert, alu_carryin;
    logic [1:0]  alu_operation;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_result;
    logic        alu_zero, alu_overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err),
        .alu_ainvert(alu_ainvert), .alu_binvert(alu_binvert), .alu_carryin(alu_carryin),
        .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow)
    );

    // External 32-bit ALU: invert/carry-in adder plus AND/OR/SLT outputs.
    logic [31:0] ea, eb, esum;
    logic        eovf;
    always_comb begin
        ea   = alu_ainvert ? ~alu_a : alu_a;
        eb   = alu_binvert ? ~alu_b : alu_b;
        esum = ea + eb + {31'b0, alu_carryin};
        eovf = (ea[31] == eb[31]) && (esum[31] != ea[31]);
        case (alu_operation)
            2'b00:   alu_result = ea & eb;
            2'b01:   alu_result = ea | eb;
            2'b10:   alu_result = esum;
            default: alu_result = {31'b0, esum[31] ^ eovf};
        endcase
        alu_zero     = (alu_result == 32'b0);
        alu_overflow = eovf;
    end

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        err;
        int          lat;
    } exp_t;

    // Reference built from plain integer arithmetic on the operands.
    function automatic exp_t ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, s;
        logic [63:0] p;
        e  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.lat = 2;
        case (op)
            3'd0: e.res = a & b;
            3'd1: e.res = a | b;
            3'd2: begin e.res = a + b; s = sa + sb; e.ovf = (s != longint'($signed(e.res))); end
            3'd3: begin e.res = a - b; s = sa - sb; e.ovf = (s != longint'($signed(a - b))); end
            3'd4: begin
                e.res = (sa < sb) ? 32'd1 : 32'd0;
                s = sa - sb;
                e.ovf = (s != longint'($signed(a - b)));
            end
            3'd5: e.res = ~(a | b);
            3'd6: begin p = {32'b0, a} * {32'b0, b}; e.res = p[31:0]; e.lat = 33; end
            default: begin e.res = 32'b0; e.err = 1'b1; e.lat = 1; end
        endcase
        e.zero = (e.res == 32'b0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input string nm);
        exp_t        e;
        int          lat, ctrl_bad, busy_bad, stab_bad;
        bit          got;
        logic [34:0] snap;
        e = ref_model(op, a, b);
        ctrl_bad = 0; busy_bad = 0; stab_bad = 0; got = 0; lat = 0;
        @(negedge clk);
        chk({nm, "/req_ready_idle"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk);
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            req_op = 3'($urandom); req_a = $urandom; req_b = $urandom;
            if (rsp_valid === 1'b1) got = 1;
            else begin
                if (req_ready !== 1'b0) busy_bad++;
                if (op == 3'd6 && {alu_ainvert, alu_binvert, alu_carryin, alu_operation} !== 5'b00010)
                    ctrl_bad++;
            end
        end
        chk({nm, "/latency"}, 32'(lat), 32'(e.lat));
        chk({nm, "/busy_not_ready"}, 32'(busy_bad), 32'd0);
        if (op == 3'd6) chk({nm, "/mul_ctrl_add"}, 32'(ctrl_bad), 32'd0);
        chk({nm, "/result"}, rsp_result, e.res);
        chk({nm, "/overflow"}, {31'b0, rsp_overflow}, {31'b0, e.ovf});
        chk({nm, "/err"}, {31'b0, rsp_err}, {31'b0, e.err});
        if (op != 3'd7) chk({nm, "/zero"}, {31'b0, rsp_zero}, {31'b0, e.zero});
        chk({nm, "/alu_idle"}, alu_a | alu_b | {27'b0, alu_ainvert, alu_binvert, alu_carryin, alu_operation}, 32'd0);
        snap = {rsp_result, rsp_zero, rsp_overflow, rsp_err};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if ({rsp_result, rsp_zero, rsp_overflow, rsp_err} !== snap || rsp_valid !== 1'b1 || req_ready !== 1'b0)
                stab_bad++;
        end
        if (hold > 0) chk({nm, "/hold_stable"}, 32'(stab_bad), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({nm, "/valid_drop"}, {31'b0, rsp_valid}, 32'd0);
        chk({nm, "/ready_after_hs"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  seen;
        reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst/req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst/rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst/rsp_fields", {rsp_result[31:3], rsp_zero, rsp_overflow, rsp_err} | {29'b0, rsp_result[2:0]}, 32'd0);
        chk("rst/alu_out", alu_a | alu_b | {27'b0, alu_ainvert, alu_binvert, alu_carryin, alu_operation}, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rst/ready_release", {31'b0, req_ready}, 32'd1);

        run_op(3'd2, 32'h7FFF_FFFF, 32'h0000_0001, 0, "add_ovf");
        run_op(3'd3, 32'd5, 32'd5, 5, "sub_zero_bp");
        run_op(3'd4, 32'hFFFF_FFFF, 32'd1, 0, "slt_neg");
        run_op(3'd6, 32'h0001_0003, 32'h0002_0005, 2, "mulu");
        run_op(3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 1, "illegal");
        run_op(3'd0, 32'hFFFF_0000, 32'h8000_8000, 0, "and_mask_ovf");
        run_op(3'd5, 32'h0F0F_0000, 32'h00F0_0F0F, 0, "nor");

        // Reset in the middle of a multiply, while the step counter is at 10.
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd6; req_a = 32'hDEAD_BEEF; req_b = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort/req_ready_in_rst", {31'b0, req_ready}, 32'd0);
        chk("abort/rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("abort/rsp_result", rsp_result, 32'd0);
        chk("abort/alu_out", alu_a | alu_b | {27'b0, alu_ainvert, alu_binvert, alu_carryin, alu_operation}, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("abort/ready_release", {31'b0, req_ready}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen++;
        end
        chk("abort/no_rsp_pulse", 32'(seen), 32'd0);

        for (int i = 0; i < 24; i++)
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   $urandom_range(0, 2), $sformatf("rand%0d", i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
